// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   - default address/data widths
//   - port-index constants (CPU is port 0, DMA/loader is port 1)
//   - grant-select encoding used by the arbitration logic
//   - width of the per-port starvation counters (large enough for MAX_WAIT up to 15)
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } gnt_sel_e;

endpackage

// File: rtl/dmem_arbiter_wait_ctr.sv
// arb_wait_ctr: saturating starvation counter, one instance per requester.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : requester is asking and was not granted this cycle
//   clr        : requester was granted or is not asking
//   sat        : counter has reached MAX_WAIT (force-grant candidate)
module arb_wait_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CNT_W-1:0] cnt;

    assign sat = (cnt == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data_mem between the CPU (port 0)
// and the debug/loader DMA (port 1). At most one access is granted per cycle;
// read data is registered and returned the cycle after the grant.
//
// Handshake: a requester raises pN_req with pN_we/pN_addr/pN_wdata stable and
// holds them until it sees pN_gnt=1 in the same cycle; the access happens on
// the clk edge that closes a cycle with req && gnt. pN_rvalid is a one-cycle
// pulse with no back-pressure; pN_rdata holds until the next read grant.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   pN_req/we/addr/wdata            request side of port N
//   pN_gnt                          combinational grant for port N
//   pN_rvalid/pN_rdata              registered read return for port N
//   o_mem_read_address              to data_mem r_address (combinational read)
//   o_mem_write_address/data/enable to data_mem write port
//   i_mem_read_data                 from data_mem o_data
//
// Build option: DMEM_ARB_ROUND_ROBIN_EN makes uncontested-by-starvation
// contention alternate between ports; otherwise the CPU port has priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] o_mem_read_address,
    output logic [ADDR_W-1:0] o_mem_write_address,
    output logic [DATA_W-1:0] o_mem_write_data,
    output logic              o_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_read_data
);

    gnt_sel_e sel;
    logic     sat0, sat1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Starts at the DMA port so the CPU wins the first contention.
    logic last_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= PORT_DMA;
        end else if (p0_gnt) begin
            last_grant <= PORT_CPU;
        end else if (p1_gnt) begin
            last_grant <= PORT_DMA;
        end
    end
`endif

    arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (p0_req && !p0_gnt),
        .clr   (!p0_req || p0_gnt),
        .sat   (sat0)
    );

    arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (p1_req && !p1_gnt),
        .clr   (!p1_req || p1_gnt),
        .sat   (sat1)
    );

    // Grant selection; the counters come from registers so there is no
    // combinational path from grant back into sat.
    always_comb begin
        sel = GNT_NONE;
        if (rst_n) begin
            if (p0_req && !p1_req) begin
                sel = GNT_P0;
            end else if (!p0_req && p1_req) begin
                sel = GNT_P1;
            end else if (p0_req && p1_req) begin
                if (sat0 && !sat1) begin
                    sel = GNT_P0;
                end else if (sat1 && !sat0) begin
                    sel = GNT_P1;
                end else if (sat0 && sat1) begin
                    sel = GNT_P0;
                end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    sel = (last_grant == PORT_DMA) ? GNT_P0 : GNT_P1;
`else
                    sel = GNT_P0;
`endif
                end
            end
        end
    end

    assign p0_gnt = (sel == GNT_P0);
    assign p1_gnt = (sel == GNT_P1);

    always_comb begin
        o_mem_read_address  = '0;
        o_mem_write_address = '0;
        o_mem_write_data    = '0;
        o_mem_write_enable  = 1'b0;
        if (p0_gnt) begin
            if (p0_we) begin
                o_mem_write_enable  = 1'b1;
                o_mem_write_address = p0_addr;
                o_mem_write_data    = p0_wdata;
            end else begin
                o_mem_read_address  = p0_addr;
            end
        end else if (p1_gnt) begin
            if (p1_we) begin
                o_mem_write_enable  = 1'b1;
                o_mem_write_address = p1_addr;
                o_mem_write_data    = p1_wdata;
            end else begin
                o_mem_read_address  = p1_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rvalid <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= p0_gnt && !p0_we;
            p1_rvalid <= p1_gnt && !p1_we;
            if (p0_gnt && !p0_we) begin
                p0_rdata <= i_mem_read_data;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata <= i_mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam int DROP_N = 1;
`else
    localparam int DROP_N = 2;
`endif

    logic          clk;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] o_mem_read_address, o_mem_write_address;
    logic [DW-1:0] o_mem_write_data, i_mem_read_data;
    logic          o_mem_write_enable;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic          exp_rv0, exp_rv1;
    int            vectors, miscompares, we_cnt;
    logic [DW-1:0] old30;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .p0_req              (p0_req),
        .p0_we               (p0_we),
        .p0_addr             (p0_addr),
        .p0_wdata            (p0_wdata),
        .p0_gnt              (p0_gnt),
        .p0_rvalid           (p0_rvalid),
        .p0_rdata            (p0_rdata),
        .p1_req              (p1_req),
        .p1_we               (p1_we),
        .p1_addr             (p1_addr),
        .p1_wdata            (p1_wdata),
        .p1_gnt              (p1_gnt),
        .p1_rvalid           (p1_rvalid),
        .p1_rdata            (p1_rdata),
        .o_mem_read_address  (o_mem_read_address),
        .o_mem_write_address (o_mem_write_address),
        .o_mem_write_data    (o_mem_write_data),
        .o_mem_write_enable  (o_mem_write_enable),
        .i_mem_read_data     (i_mem_read_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_mem model: combinational read, write on the rising edge
    assign i_mem_read_data = mem[o_mem_read_address];
    always @(posedge clk) begin
        if (o_mem_write_enable) mem[o_mem_write_address] <= o_mem_write_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on read grant, pop/compare when rvalid is due.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        check("p0_rvalid", p0_rvalid, exp_rv0);
        check("p1_rvalid", p1_rvalid, exp_rv1);
        check("one_grant", p0_gnt & p1_gnt, 1'b0);
        if (exp_rv0) begin
            e = exp_q0.pop_front();
            check("p0_rdata_sb", p0_rdata, e);
        end
        if (exp_rv1) begin
            e = exp_q1.pop_front();
            check("p1_rdata_sb", p1_rdata, e);
        end
        if (o_mem_write_enable) we_cnt++;
        exp_rv0 = rst_n && p0_gnt && !p0_we;
        exp_rv1 = rst_n && p1_gnt && !p1_we;
        if (exp_rv0) exp_q0.push_back(ref_mem[p0_addr]);
        if (exp_rv1) exp_q1.push_back(ref_mem[p1_addr]);
        if (rst_n && p0_gnt && p0_we) ref_mem[p0_addr] = p0_wdata;
        if (rst_n && p1_gnt && p1_we) ref_mem[p1_addr] = p1_wdata;
    end

    // Both ports request reads every cycle; expected grant pattern derived
    // from the arbitration policy (fixed: p1 every 5th; RR: alternation).
    task automatic contend(input int n, input bit p1_first);
        logic exp_p1;
        for (int k = 1; k <= n; k++) begin
            p0_req  = 1'b1;
            p0_we   = 1'b0;
            p0_addr = AW'($urandom_range(0, 255));
            p1_req  = 1'b1;
            p1_we   = 1'b0;
            p1_addr = AW'($urandom_range(0, 255));
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_p1 = p1_first ? (k % 2 == 1) : (k % 2 == 0);
`else
            exp_p1 = (k % 5 == 0);
            if (p1_first) exp_p1 = (k % 5 == 0);
`endif
            @(negedge clk);
            check("cont_p0_gnt", p0_gnt, !exp_p1);
            check("cont_p1_gnt", p1_gnt, exp_p1);
            tick();
        end
    endtask

    initial begin
        int w0;
        vectors     = 0;
        miscompares = 0;
        we_cnt      = 0;
        exp_rv0     = 1'b0;
        exp_rv1     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8'h10]     = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;

        // reset with a write request held: grant and write must stay off
        rst_n    = 1'b0;
        p0_req   = 1'b1;
        p0_we    = 1'b1;
        p0_addr  = 8'h10;
        p0_wdata = 32'h0BADF00D;
        p1_req   = 1'b0;
        p1_we    = 1'b0;
        p1_addr  = '0;
        p1_wdata = '0;
        @(negedge clk);
        check("rst_p0_gnt", p0_gnt, 1'b0);
        check("rst_we", o_mem_write_enable, 1'b0);
        tick();
        rst_n  = 1'b1;
        p0_req = 1'b0;
        p0_we  = 1'b0;
        @(negedge clk);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
        check("idle_raddr", o_mem_read_address, 8'h0);
        check("idle_waddr", o_mem_write_address, 8'h0);

        // single p0 read of 0x10
        tick();
        p0_req  = 1'b1;
        p0_addr = 8'h10;
        @(negedge clk);
        check("rd_p0_gnt", p0_gnt, 1'b1);
        check("rd_raddr", o_mem_read_address, 8'h10);
        tick();
        p0_req = 1'b0;
        @(negedge clk);
        check("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);

        // p1 write 0x20 then read-after-write
        tick();
        w0       = we_cnt;
        p1_req   = 1'b1;
        p1_we    = 1'b1;
        p1_addr  = 8'h20;
        p1_wdata = 32'h12345678;
        @(negedge clk);
        check("wr_p1_gnt", p1_gnt, 1'b1);
        check("wr_we", o_mem_write_enable, 1'b1);
        check("wr_waddr", o_mem_write_address, 8'h20);
        check("wr_wdata", o_mem_write_data, 32'h12345678);
        tick();
        p1_we = 1'b0;
        @(negedge clk);
        check("raw_p1_gnt", p1_gnt, 1'b1);
        check("raw_we", o_mem_write_enable, 1'b0);
        tick();
        p1_req = 1'b0;
        @(negedge clk);
        check("raw_p1_rdata", p1_rdata, 32'h12345678);
        check("wr_pulses", we_cnt - w0, 1);

        // read grant, then reset in the next cycle with a write held
        tick();
        old30   = ref_mem[8'h30];
        p0_req  = 1'b1;
        p0_we   = 1'b0;
        p0_addr = 8'h30;
        @(negedge clk);
        check("pre_rst_gnt", p0_gnt, 1'b1);
        tick();
        rst_n    = 1'b0;
        p0_we    = 1'b1;
        p0_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        check("midrst_gnt", p0_gnt, 1'b0);
        check("midrst_we", o_mem_write_enable, 1'b0);
        tick();
        rst_n = 1'b1;
        p0_we = 1'b0;

        // first contention after reset goes to p0
        contend(20, 1'b0);

        // p1 asks briefly while p0 wins, then withdraws: its counter clears
        for (int i = 0; i < DROP_N; i++) begin
            p0_req = 1'b1;
            p1_req = 1'b1;
            @(negedge clk);
            check("drop_p1_gnt", p1_gnt, 1'b0);
            check("drop_p0_gnt", p0_gnt, 1'b1);
            tick();
        end
        p1_req = 1'b0;
        @(negedge clk);
        check("drop_idle_p0", p0_gnt, 1'b1);
        tick();
        contend(10, 1'b1);

        // suppressed write must not have reached 0x30
        p1_req  = 1'b0;
        p0_req  = 1'b1;
        p0_we   = 1'b0;
        p0_addr = 8'h30;
        @(negedge clk);
        check("rb_p0_gnt", p0_gnt, 1'b1);
        tick();
        p0_req = 1'b0;
        @(negedge clk);
        check("rb_p0_rdata", p0_rdata, old30);
        check("end_we", o_mem_write_enable, 1'b0);
        tick();
        @(negedge clk);
        check("q0_empty", exp_q0.size(), 0);
        check("q1_empty", exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
